// File: rtl/disp_pkg.sv
// Shared definitions for the decimal display / entry path.
// Holds the converter state encoding and the BCD digit width.
package disp_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
    return digit > BCD_DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double dabble correction cell: after a right shift, a BCD digit
// that reads 8 or more has picked up a half-ten weight and loses 3.
module bcd_digit_adj
  import disp_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= BCD_DIGIT_W'(8)) ? digit - BCD_DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble, one bit per clock)
// with start/busy/done handshake, invalid-digit flag and saturation on overflow.
module bcd_to_bin
  import disp_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_in,
  output logic                            busy,
  output logic                            done,
  output logic [BIN_W-1:0]                bin_out,
  output logic                            ovf,
  output logic                            err_digit
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = 2 * BCD_W;
  localparam int CNT_W = $clog2(BCD_W + 1);
  localparam int EXT_W = (BCD_W > BIN_W) ? BCD_W : BIN_W;

  state_t           state, state_next;
  logic [SR_W-1:0]  sr, sr_next, sr_shift, sr_adj;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [BIN_W-1:0] bin_next;
  logic             ovf_next, err_next;
  logic             bad_digit;
  logic [EXT_W-1:0] res_ext;
  logic             res_ovf;

  // Upper half holds the remaining BCD digits; the binary result grows in the lower half.
  assign sr_shift = sr >> 1;
  assign sr_adj[BCD_W-1:0] = sr_shift[BCD_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (sr_shift[BCD_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (sr_adj[BCD_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) bad_digit = 1'b1;
    end
  end

  // Overflow is judged on the full unsaturated result before any truncation.
  assign res_ext = EXT_W'(sr[BCD_W-1:0]);
  assign res_ovf = |(res_ext >> BIN_W);

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      bin_out   <= '0;
      ovf       <= 1'b0;
      err_digit <= 1'b0;
    end else begin
      state     <= state_next;
      sr        <= sr_next;
      cnt       <= cnt_next;
      bin_out   <= bin_next;
      ovf       <= ovf_next;
      err_digit <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    bin_next   = bin_out;
    ovf_next   = ovf;
    err_next   = err_digit;

    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          sr_next  = {bcd_in, {BCD_W{1'b0}}};
          cnt_next = '0;
          if (bad_digit) begin
            err_next   = 1'b1;
            bin_next   = '0;
            ovf_next   = 1'b0;
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        // One extra cycle after the last shift lets the result settle before saturation.
        if (cnt == CNT_W'(BCD_W)) begin
          state_next = DONE;
          err_next   = 1'b0;
          ovf_next   = res_ovf;
          bin_next   = res_ovf ? '1 : res_ext[BIN_W-1:0];
        end else begin
          sr_next  = sr_adj;
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table, handshake corner cases,
// reset abort and a random sweep against an arithmetic reference model.
module tb_bcd_to_bin;

  localparam int DIGITS  = 5;
  localparam int BIN_W   = 16;
  localparam int LAT     = 4*DIGITS + 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [19:0]       bcd_in;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin_out;
  logic              ovf;
  logic              err_digit;

  int checks = 0;
  int errors = 0;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .bin_out   (bin_out),
    .ovf       (ovf),
    .err_digit (err_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bcd;
    logic [15:0] bin;
    logic        ovf;
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: decimal value by place weights, then saturate.
  task automatic ref_model(input logic [19:0] bcd, output logic [15:0] bin,
                           output logic ovf_r, output logic err_r);
    int value = 0;
    int weight = 1;
    err_r = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) err_r = 1'b1;
      value += int'(bcd[4*i +: 4]) * weight;
      weight *= 10;
    end
    if (err_r) begin
      bin = '0; ovf_r = 1'b0;
    end else if (value > 65535) begin
      bin = 16'hFFFF; ovf_r = 1'b1;
    end else begin
      bin = 16'(value); ovf_r = 1'b0;
    end
  endtask

  function automatic logic [19:0] bcd_of(input int v);
    logic [19:0] r = '0;
    int rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  function automatic logic [19:0] rand_bcd();
    logic [19:0] r;
    if ($urandom_range(7) == 0) return 20'($urandom);
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  // Start one conversion; report edges from accept to done, and busy/done behaviour.
  task automatic applyStimulus(input logic [19:0] bcd, output int lat,
                               output int busy_bad, output logic done_after);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 20'($urandom);
    lat = -1;
    busy_bad = 0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (done) begin
        lat = e;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      bcd_in = 20'($urandom);
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic checkOutput(input string name, input logic [19:0] bcd, input int lat,
                             input int busy_bad, input logic done_after);
    logic [15:0] eb;
    logic        eo, ee;
    ref_model(bcd, eb, eo, ee);
    check({name, ".bin"},  32'(bin_out),   32'(eb));
    check({name, ".ovf"},  32'(ovf),       32'(eo));
    check({name, ".err"},  32'(err_digit), 32'(ee));
    check({name, ".lat"},  32'(lat),       ee ? 32'd0 : 32'(LAT));
    check({name, ".busy"}, 32'(busy_bad),  32'd0);
    check({name, ".pulse"}, 32'(done_after), 32'd0);
  endtask

  task automatic run_one(input string name, input logic [19:0] bcd);
    int lat, bb;
    logic da;
    applyStimulus(bcd, lat, bb, da);
    checkOutput(name, bcd, lat, bb, da);
  endtask

  initial begin
    vec_t vecs[10];
    logic [19:0] q[$];
    int nconv;
    int dseen;

    vecs[0] = '{20'h12345, 16'h3039, 1'b0, 1'b0};
    vecs[1] = '{20'h65535, 16'hFFFF, 1'b0, 1'b0};
    vecs[2] = '{20'h65536, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{20'h99999, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{20'h00000, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{20'h1A000, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{20'h00042, 16'h002A, 1'b0, 1'b0};
    vecs[7] = '{20'h90000, 16'hFFFF, 1'b1, 1'b0};
    vecs[8] = '{20'h0000F, 16'h0000, 1'b0, 1'b1};
    vecs[9] = '{20'h00009, 16'h0009, 1'b0, 1'b0};

    rst_n = 1'b1; start = 1'b0; bcd_in = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.busy", 32'(busy), 0);
    check("reset.done", 32'(done), 0);
    check("reset.bin",  32'(bin_out), 0);
    check("reset.ovf",  32'(ovf), 0);
    check("reset.err",  32'(err_digit), 0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      int lat, bb;
      logic da;
      applyStimulus(vecs[k].bcd, lat, bb, da);
      check($sformatf("vec%0d.bin", k), 32'(bin_out),   32'(vecs[k].bin));
      check($sformatf("vec%0d.ovf", k), 32'(ovf),       32'(vecs[k].ovf));
      check($sformatf("vec%0d.err", k), 32'(err_digit), 32'(vecs[k].err));
      checkOutput($sformatf("vec%0d", k), vecs[k].bcd, lat, bb, da);
    end

    // Back-to-back: start held high, operand changes every cycle.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = rand_bcd();
    q.push_back(bcd_in);
    nconv = 0;
    for (int cyc = 0; cyc < 220; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          check("b2b.spurious_done", 32'd1, 32'd0);
        end else begin
          logic [19:0] cap;
          logic [15:0] eb;
          logic eo, ee;
          cap = q.pop_front();
          ref_model(cap, eb, eo, ee);
          check("b2b.bin", 32'(bin_out),   32'(eb));
          check("b2b.ovf", 32'(ovf),       32'(eo));
          check("b2b.err", 32'(err_digit), 32'(ee));
          nconv++;
        end
      end
      if (cyc < 150) begin
        bcd_in = rand_bcd();
        if (done) q.push_back(bcd_in);
      end else begin
        start = 1'b0;
      end
    end
    check("b2b.pending", 32'(q.size()), 0);
    check("b2b.enough", 32'(nconv >= 5), 1);

    // Reset in the middle of a conversion aborts it.
    run_one("pre_reset", 20'h12345);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 20'h00042;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 0);
    check("abort.done", 32'(done), 0);
    check("abort.bin",  32'(bin_out), 0);
    check("abort.ovf",  32'(ovf), 0);
    check("abort.err",  32'(err_digit), 0);
    dseen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done) dseen++;
    end
    check("abort.no_done", 32'(dseen), 0);
    run_one("after_reset", 20'h00042);
    check("after_reset.value", 32'(bin_out), 32'h2A);

    // Random sweep with round trip back to BCD.
    for (int n = 0; n < 40; n++) begin
      int v;
      logic [19:0] b;
      v = (n == 0) ? 65535 : (n == 1) ? 65536 : int'($urandom_range(99999));
      b = bcd_of(v);
      run_one("sweep", b);
      check("sweep.value", 32'(bin_out), (v > 65535) ? 32'hFFFF : 32'(v));
      if (v <= 65535) check("sweep.roundtrip", 32'(bcd_of(int'(bin_out))), 32'(b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
